operand2_encoder: RTL and testbench

Multi-cycle encoder that converts a 32-bit constant into the ARM data-processing rotate-immediate form `{rot4, imm8}`. It is the inverse of the operand-2 immediate expansion, which computes value = ROR(zero-extended imm8, 2·rot4). Optionally, it also tries the bitwise-inverted constant so that the caller can emit MVN/BIC forms. It sits beside the ID/EXE path as a helper for the in-design instruction builder and the self-test sequencer, using valid/ready handshakes on both sides.

---
 rtl/arm_pkg.sv | 31 +++
 rtl/operand2_rot_check.sv | 24 ++
 rtl/operand2_encoder.sv | 107 ++++++++++
 tb/tb_operand2_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM operand-2 definitions: encoder FSM states, field widths and
// the {rot4, imm8} layout used by both the encoder and the expansion logic.
package arm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } enc_state_t;

  localparam int ROT_W      = 4;
  localparam int IMM_W      = 8;
  localparam int OPERAND2_W = 12;

  localparam int IMM_LSB = 0;
  localparam int IMM_MSB = IMM_LSB + IMM_W - 1;
  localparam int ROT_LSB = IMM_MSB + 1;
  localparam int ROT_MSB = ROT_LSB + ROT_W - 1;

  function automatic logic [OPERAND2_W-1:0] pack_operand2(
    input logic [ROT_W-1:0] rot,
    input logic [IMM_W-1:0] imm
  );
    logic [OPERAND2_W-1:0] op;
    op = '0;
    op[ROT_MSB:ROT_LSB] = rot;
    op[IMM_MSB:IMM_LSB] = imm;
    return op;
  endfunction

endpackage

// File: rtl/operand2_rot_check.sv
// Combinational fit test: does ROL(value, 2r) collapse into the low imm8 byte?
module operand2_rot_check
  import arm_pkg::*;
(
  input  logic [31:0]      value,
  input  logic [ROT_W-1:0] r,
  output logic             fit,
  output logic [IMM_W-1:0] imm8
);

  logic [4:0]  shamt;
  logic [63:0] dbl;
  logic [31:0] t;

  // Upper half of the doubled word shifted left is a rotate-left.
  always_comb begin
    shamt = {r, 1'b0};
    dbl   = {value, value} << shamt;
    t     = dbl[63:32];
    fit   = (t[31:IMM_W] == '0);
    imm8  = t[IMM_W-1:0];
  end

endmodule

// File: rtl/operand2_encoder.sv
// Multi-cycle search for the canonical ARM rotate-immediate {rot4, imm8}
// encoding of a 32-bit constant, optionally also trying its complement.
module operand2_encoder
  import arm_pkg::*;
#(
  parameter bit TRY_INVERT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_ok,
  output logic                  out_invert,
  output logic [OPERAND2_W-1:0] out_shift_operand,
  output logic                  busy
);

  enc_state_t       state;
  logic [31:0]      val_q;
  logic [ROT_W-1:0] r_q;

  logic             fit_pos, fit_inv;
  logic [IMM_W-1:0] imm_pos, imm_inv;

  operand2_rot_check u_chk_pos (
    .value (val_q),
    .r     (r_q),
    .fit   (fit_pos),
    .imm8  (imm_pos)
  );

  generate
    if (TRY_INVERT) begin : g_inv
      operand2_rot_check u_chk_inv (
        .value (~val_q),
        .r     (r_q),
        .fit   (fit_inv),
        .imm8  (imm_inv)
      );
    end else begin : g_no_inv
      assign fit_inv = 1'b0;
      assign imm_inv = '0;
    end
  endgenerate

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      val_q             <= '0;
      r_q               <= '0;
      out_valid         <= 1'b0;
      out_ok            <= 1'b0;
      out_invert        <= 1'b0;
      out_shift_operand <= '0;
      busy              <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            val_q <= in_value;
            r_q   <= '0;
            busy  <= 1'b1;
            state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          // Plain value beats the complement at equal rotation; lowest r wins.
          if (fit_pos) begin
            out_ok            <= 1'b1;
            out_invert        <= 1'b0;
            out_shift_operand <= pack_operand2(r_q, imm_pos);
            out_valid         <= 1'b1;
            state             <= ST_DONE;
          end else if (fit_inv) begin
            out_ok            <= 1'b1;
            out_invert        <= 1'b1;
            out_shift_operand <= pack_operand2(r_q, imm_inv);
            out_valid         <= 1'b1;
            state             <= ST_DONE;
          end else if (r_q == '1) begin
            out_ok            <= 1'b0;
            out_invert        <= 1'b0;
            out_shift_operand <= '0;
            out_valid         <= 1'b1;
            state             <= ST_DONE;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand2_encoder.sv
// Bench for operand2_encoder: one instance with complement search, one without,
// driven with shared requests and checked against a brute-force expansion model.
module tb_operand2_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_value = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ok_a, out_invert_a, busy_a;
  logic [11:0] op_a;
  logic        in_ready_b, out_valid_b, out_ok_b, out_invert_b, busy_b;
  logic [11:0] op_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand2_encoder #(.TRY_INVERT(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_value(in_value), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ok(out_ok_a), .out_invert(out_invert_a), .out_shift_operand(op_a),
    .busy(busy_a)
  );

  operand2_encoder #(.TRY_INVERT(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_value(in_value), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ok(out_ok_b), .out_invert(out_invert_b), .out_shift_operand(op_b),
    .busy(busy_b)
  );

  typedef struct {
    logic        ok;
    logic        inv;
    logic [11:0] op;
    int          lat;
  } res_t;

  typedef struct {
    logic [31:0] value;
    logic        ok_a;
    logic        inv_a;
    logic [11:0] op_a;
    int          lat_a;
    logic        ok_b;
    logic [11:0] op_b;
    int          lat_b;
  } vec_t;

  // Operand-2 expansion: ROR(zero-extended imm8, 2*rot4).
  function automatic logic [31:0] expand(input logic [11:0] op);
    logic [31:0] z;
    int s;
    z = {24'd0, op[7:0]};
    s = 2 * int'(op[11:8]);
    if (s == 0) return z;
    return (z >> s) | (z << (32 - s));
  endfunction

  // Brute force over every (rot, imm) pair; lowest rotation, plain first.
  function automatic res_t model(input logic [31:0] v, input bit try_inv);
    res_t res;
    logic [11:0] op;
    res.ok = 1'b0; res.inv = 1'b0; res.op = '0; res.lat = 16;
    for (int r = 0; r < 16; r++) begin
      for (int imm = 0; imm < 256; imm++) begin
        op = {r[3:0], imm[7:0]};
        if (expand(op) == v) begin
          res.ok = 1'b1; res.op = op; res.lat = r + 1;
          return res;
        end
      end
      if (try_inv) begin
        for (int imm = 0; imm < 256; imm++) begin
          op = {r[3:0], imm[7:0]};
          if (expand(op) == ~v) begin
            res.ok = 1'b1; res.inv = 1'b1; res.op = op; res.lat = r + 1;
            return res;
          end
        end
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // Issue one request to both instances; report first out_valid cycle of each.
  task automatic request(input logic [31:0] v, output int lat_a, output int lat_b);
    chk("in_ready_a_before_req", {31'd0, in_ready_a}, 32'd1);
    chk("in_ready_b_before_req", {31'd0, in_ready_b}, 32'd1);
    in_value = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat_a = 0; lat_b = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (lat_a == 0 && out_valid_a) lat_a = c;
      if (lat_b == 0 && out_valid_b) lat_b = c;
      if (lat_a != 0 && lat_b != 0) break;
    end
    if (lat_a == 0) lat_a = 99;
    if (lat_b == 0) lat_b = 99;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after_pop", {30'd0, in_ready_a, in_ready_b}, 32'd3);
    chk("busy_after_pop", {30'd0, busy_a, busy_b}, 32'd0);
    chk("out_valid_after_pop", {30'd0, out_valid_a, out_valid_b}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] v,
                              input res_t ea, input res_t eb,
                              input int la, input int lb);
    chk({tag, "_ok_a"}, {31'd0, out_ok_a}, {31'd0, ea.ok});
    chk({tag, "_inv_a"}, {31'd0, out_invert_a}, {31'd0, ea.inv});
    chk({tag, "_op_a"}, {20'd0, op_a}, {20'd0, ea.op});
    chk({tag, "_lat_a"}, la, ea.lat);
    chk({tag, "_ok_b"}, {31'd0, out_ok_b}, {31'd0, eb.ok});
    chk({tag, "_inv_b"}, {31'd0, out_invert_b}, 32'd0);
    chk({tag, "_op_b"}, {20'd0, op_b}, {20'd0, eb.op});
    chk({tag, "_lat_b"}, lb, eb.lat);
    if (ea.ok) chk({tag, "_roundtrip_a"}, expand(op_a), out_invert_a ? ~v : v);
  endtask

  vec_t vecs[8];

  initial begin
    int la, lb;
    res_t ea, eb;
    logic [31:0] v;
    logic [11:0] seed_op;

    vecs[0] = '{32'h0000_00FF, 1'b1, 1'b0, 12'h0FF, 1,  1'b1, 12'h0FF, 1};
    vecs[1] = '{32'hFF00_0000, 1'b1, 1'b0, 12'h4FF, 5,  1'b1, 12'h4FF, 5};
    vecs[2] = '{32'h0000_0104, 1'b1, 1'b0, 12'hF41, 16, 1'b1, 12'hF41, 16};
    vecs[3] = '{32'hFFFF_FF00, 1'b1, 1'b1, 12'h0FF, 1,  1'b0, 12'h000, 16};
    vecs[4] = '{32'h0000_0101, 1'b0, 1'b0, 12'h000, 16, 1'b0, 12'h000, 16};
    vecs[5] = '{32'h0000_0000, 1'b1, 1'b0, 12'h000, 1,  1'b1, 12'h000, 1};
    vecs[6] = '{32'h3FC0_0000, 1'b1, 1'b0, 12'h5FF, 6,  1'b1, 12'h5FF, 6};
    vecs[7] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 12'h000, 1,  1'b0, 12'h000, 16};

    // Reset state
    #12;
    chk("rst_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd3);
    chk("rst_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd0);
    chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
    chk("rst_ok_inv", {28'd0, out_ok_a, out_invert_a, out_ok_b, out_invert_b}, 32'd0);
    chk("rst_op", {8'd0, op_a, op_b}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      ea = '{vecs[i].ok_a, vecs[i].inv_a, vecs[i].op_a, vecs[i].lat_a};
      eb = '{vecs[i].ok_b, 1'b0, vecs[i].op_b, vecs[i].lat_b};
      request(vecs[i].value, la, lb);
      check_result($sformatf("vec%0d", i), vecs[i].value, ea, eb, la, lb);
      pop();
    end

    // Backpressure on an unencodable constant; new request must be ignored
    request(32'h0000_0101, la, lb);
    chk("bp_lat", la, 16);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin in_value = 32'h0000_00FF; in_valid = 1'b1; end
      @(posedge clk); #1;
      chk("bp_out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd3);
      chk("bp_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd0);
      chk("bp_ok", {30'd0, out_ok_a, out_ok_b}, 32'd0);
      chk("bp_op", {8'd0, op_a, op_b}, 32'd0);
    end
    in_valid = 1'b0;
    pop();
    @(posedge clk); #1;
    chk("bp_no_new_req", {30'd0, busy_a, busy_b}, 32'd0);

    // Get a nonzero result latched, then reset in the middle of a long search
    request(32'h0000_00FF, la, lb);
    pop();
    in_value = 32'h0000_0104;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_state", {26'd0, in_ready_a, out_valid_a, busy_a, out_ok_a, in_ready_b, busy_b},
        32'b100010);
    chk("mid_rst_op", {8'd0, op_a, op_b}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd3);
    request(32'h3FC0_0000, la, lb);
    chk("post_rst_op_a", {20'd0, op_a}, 32'h5FF);
    chk("post_rst_op_b", {20'd0, op_b}, 32'h5FF);
    chk("post_rst_lat", la, 6);
    pop();

    // Randomized values against the brute-force model
    for (int i = 0; i < 50; i++) begin
      seed_op = 12'($urandom);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = expand(seed_op);
        2: v = ~expand(seed_op);
        default: v = expand(seed_op) ^ (32'd1 << $urandom_range(0, 31));
      endcase
      ea = model(v, 1'b1);
      eb = model(v, 1'b0);
      request(v, la, lb);
      check_result($sformatf("rnd%0d", i), v, ea, eb, la, lb);
      pop();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
